// File: rtl/pong_game_fsm.sv
// Pong game sequencer: serve, miss detection, scoring, post-point hold and winner.
// Latency: a miss seen in cycle N updates score/state/outputs at edge N+1; all outputs registered.
// Backpressure: none; ball controller is gated through o_Game_Active (1 only while RUNNING).
//
// Ports:
//   i_Clk, i_Rst          clock, asynchronous active-high reset
//   i_Start               debounced start/serve level, rising edge acts
//   i_Ball_X, i_Ball_Y    ball position from the ball controller
//   i_Paddle_Y_P1/P2      top row of each paddle (P1 at column 0, P2 at last column)
//   o_Game_Active         ball controller enable
//   o_P1_Score/o_P2_Score per-player points
//   o_Game_Over, o_Winner end-of-game flag and winner (0 = P1, 1 = P2)
module pong_game_fsm #(
  parameter int c_GAME_WIDTH    = 40,
  parameter int c_GAME_HEIGHT   = 30,
  parameter int c_PADDLE_HEIGHT = 6,
  parameter int c_SCORE_LIMIT   = 9,
  parameter int c_POINT_HOLD    = 25000000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Start,
  input  logic [5:0] i_Ball_X,
  input  logic [5:0] i_Ball_Y,
  input  logic [5:0] i_Paddle_Y_P1,
  input  logic [5:0] i_Paddle_Y_P2,
  output logic       o_Game_Active,
  output logic [3:0] o_P1_Score,
  output logic [3:0] o_P2_Score,
  output logic       o_Game_Over,
  output logic       o_Winner
);

  typedef enum logic [1:0] {IDLE, RUNNING, POINT, GAME_OVER} state_t;

  // Counter only has to reach c_POINT_HOLD-1.
  localparam int c_CNT_W = (c_POINT_HOLD > 1) ? $clog2(c_POINT_HOLD) : 1;
  localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(c_POINT_HOLD - 1);
  localparam logic [5:0] c_P2_COL   = 6'(c_GAME_WIDTH - 1);
  localparam logic [6:0] c_PAD_SPAN = 7'(c_PADDLE_HEIGHT - 1);
  localparam logic [4:0] c_LIMIT    = 5'(c_SCORE_LIMIT);

  // Elaboration-time range check of the board and scoring parameters.
  if (c_GAME_WIDTH < 2 || c_GAME_WIDTH > 64 || c_GAME_HEIGHT < 1 || c_GAME_HEIGHT > 64 ||
      c_PADDLE_HEIGHT < 1 || c_SCORE_LIMIT < 1 || c_SCORE_LIMIT > 15 || c_POINT_HOLD < 1)
  begin : g_bad_params
    $error("pong_game_fsm: parameter out of range");
  end

  state_t               r_State;
  logic                 r_Start_Prev;
  logic [c_CNT_W-1:0]   r_Hold_Cnt;

  logic                 w_Start_Pulse;
  logic                 w_Hit_P1, w_Hit_P2;
  logic                 w_Miss_P1, w_Miss_P2;
  logic [4:0]           w_P1_Next, w_P2_Next;

  assign w_Start_Pulse = i_Start & ~r_Start_Prev;

  // 7-bit compare so paddle top + height cannot wrap near the bottom edge.
  assign w_Hit_P1 = ({1'b0, i_Ball_Y} >= {1'b0, i_Paddle_Y_P1}) &&
                    ({1'b0, i_Ball_Y} <= ({1'b0, i_Paddle_Y_P1} + c_PAD_SPAN));
  assign w_Hit_P2 = ({1'b0, i_Ball_Y} >= {1'b0, i_Paddle_Y_P2}) &&
                    ({1'b0, i_Ball_Y} <= ({1'b0, i_Paddle_Y_P2} + c_PAD_SPAN));

  assign w_Miss_P1 = (i_Ball_X == 6'd0)     && !w_Hit_P1;
  assign w_Miss_P2 = (i_Ball_X == c_P2_COL) && !w_Hit_P2;

  // One bit wider than the score so the limit compare sees the true sum.
  assign w_P1_Next = {1'b0, o_P1_Score} + 5'd1;
  assign w_P2_Next = {1'b0, o_P2_Score} + 5'd1;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_State       <= IDLE;
      r_Start_Prev  <= 1'b0;
      r_Hold_Cnt    <= '0;
      o_Game_Active <= 1'b0;
      o_P1_Score    <= 4'd0;
      o_P2_Score    <= 4'd0;
      o_Game_Over   <= 1'b0;
      o_Winner      <= 1'b0;
    end else begin
      r_Start_Prev <= i_Start;
      case (r_State)
        IDLE: begin
          if (w_Start_Pulse) begin
            r_State       <= RUNNING;
            o_Game_Active <= 1'b1;
            o_P1_Score    <= 4'd0;
            o_P2_Score    <= 4'd0;
          end
        end
        RUNNING: begin
          // Leaving RUNNING on the miss edge is what stops a lingering ball
          // from scoring twice. P1 miss takes priority.
          if (w_Miss_P1) begin
            o_P2_Score    <= w_P2_Next[3:0];
            o_Game_Active <= 1'b0;
            if (w_P2_Next == c_LIMIT) begin
              r_State     <= GAME_OVER;
              o_Game_Over <= 1'b1;
              o_Winner    <= 1'b1;
            end else begin
              r_State    <= POINT;
              r_Hold_Cnt <= '0;
            end
          end else if (w_Miss_P2) begin
            o_P1_Score    <= w_P1_Next[3:0];
            o_Game_Active <= 1'b0;
            if (w_P1_Next == c_LIMIT) begin
              r_State     <= GAME_OVER;
              o_Game_Over <= 1'b1;
              o_Winner    <= 1'b0;
            end else begin
              r_State    <= POINT;
              r_Hold_Cnt <= '0;
            end
          end
        end
        POINT: begin
          if (r_Hold_Cnt == c_HOLD_LAST) begin
            r_State       <= RUNNING;
            o_Game_Active <= 1'b1;
          end else begin
            r_Hold_Cnt <= r_Hold_Cnt + 1'b1;
          end
        end
        GAME_OVER: begin
          if (w_Start_Pulse) begin
            r_State     <= IDLE;
            o_Game_Over <= 1'b0;
          end
        end
        default: r_State <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_fsm.sv
// Self-checking bench for pong_game_fsm with a short hold and low score limit.
// Directed scenarios plus randomized play compared against a behavioural game model.
module tb_pong_game_fsm;

  localparam int W     = 40;
  localparam int H     = 30;
  localparam int PH    = 6;
  localparam int LIMIT = 3;
  localparam int HOLD  = 4;

  logic       i_Clk = 1'b0;
  logic       i_Rst;
  logic       i_Start;
  logic [5:0] i_Ball_X, i_Ball_Y, i_Paddle_Y_P1, i_Paddle_Y_P2;
  logic       o_Game_Active;
  logic [3:0] o_P1_Score, o_P2_Score;
  logic       o_Game_Over, o_Winner;

  int checks = 0;
  int errors = 0;

  pong_game_fsm #(
    .c_GAME_WIDTH(W), .c_GAME_HEIGHT(H), .c_PADDLE_HEIGHT(PH),
    .c_SCORE_LIMIT(LIMIT), .c_POINT_HOLD(HOLD)
  ) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(i_Start),
    .i_Ball_X(i_Ball_X), .i_Ball_Y(i_Ball_Y),
    .i_Paddle_Y_P1(i_Paddle_Y_P1), .i_Paddle_Y_P2(i_Paddle_Y_P2),
    .o_Game_Active(o_Game_Active), .o_P1_Score(o_P1_Score), .o_P2_Score(o_P2_Score),
    .o_Game_Over(o_Game_Over), .o_Winner(o_Winner)
  );

  always #5 i_Clk = ~i_Clk;

  // Behavioural game model: a game is "in play" between a serve and its end;
  // hold_left counts the inactive cycles still owed after a point.
  bit m_start_prev, m_playing, m_over, m_winner;
  int m_p1, m_p2, m_hold_left;

  task automatic model_reset();
    m_start_prev = 0; m_playing = 0; m_over = 0; m_winner = 0;
    m_p1 = 0; m_p2 = 0; m_hold_left = 0;
  endtask

  task automatic model_step(input bit st, input int bx, input int by, input int p1, input int p2);
    bit pulse, hit1, hit2;
    pulse = st && !m_start_prev;
    m_start_prev = st;
    hit1 = (by >= p1) && (by <= p1 + PH - 1);
    hit2 = (by >= p2) && (by <= p2 + PH - 1);
    if (m_over) begin
      if (pulse) begin m_over = 0; m_playing = 0; end
    end else if (!m_playing) begin
      if (pulse) begin m_playing = 1; m_hold_left = 0; m_p1 = 0; m_p2 = 0; end
    end else if (m_hold_left > 0) begin
      m_hold_left = m_hold_left - 1;
    end else if (bx == 0 && !hit1) begin
      m_p2 = m_p2 + 1;
      if (m_p2 == LIMIT) begin m_over = 1; m_winner = 1; m_playing = 0; end
      else m_hold_left = HOLD;
    end else if (bx == W - 1 && !hit2) begin
      m_p1 = m_p1 + 1;
      if (m_p1 == LIMIT) begin m_over = 1; m_winner = 0; m_playing = 0; end
      else m_hold_left = HOLD;
    end
  endtask

  function automatic logic [10:0] model_vec();
    bit act;
    act = m_playing && (m_hold_left == 0) && !m_over;
    return {act, 4'(m_p1), 4'(m_p2), m_over, m_winner};
  endfunction

  function automatic logic [10:0] dut_vec();
    return {o_Game_Active, o_P1_Score, o_P2_Score, o_Game_Over, o_Winner};
  endfunction

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic tick(input bit st, input int bx, input int by, input int p1, input int p2);
    i_Start = st; i_Ball_X = 6'(bx); i_Ball_Y = 6'(by);
    i_Paddle_Y_P1 = 6'(p1); i_Paddle_Y_P2 = 6'(p2);
    model_step(st, bx, by, p1, p2);
    @(posedge i_Clk); #1;
  endtask

  task automatic do_reset();
    i_Rst = 1'b1;
    model_reset();
    @(negedge i_Clk);
    i_Rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    i_Rst = 1'b1; i_Start = 0; i_Ball_X = 0; i_Ball_Y = 0;
    i_Paddle_Y_P1 = 0; i_Paddle_Y_P2 = 0;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== 11'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", dut_vec(), 11'd0);
    end
    @(negedge i_Clk);
    i_Rst = 1'b0;
    #1;
  endtask

  task automatic test_start();
    tick(1, 20, 20, 10, 10);
    checks++;
    if (o_Game_Active !== 1'b1 || o_P1_Score !== 4'd0 || o_P2_Score !== 4'd0) begin
      errors++; $display("FAIL start_serve: act=%b p1=%0d p2=%0d expected act=1 p1=0 p2=0",
                         o_Game_Active, o_P1_Score, o_P2_Score);
    end
    tick(0, 20, 20, 10, 10);
  endtask

  task automatic test_hit_miss();
    tick(0, 0, 12, 10, 20);
    checks++;
    if (o_Game_Active !== 1'b1 || o_P2_Score !== 4'd0) begin
      errors++; $display("FAIL p1_hit: act=%b p2=%0d expected act=1 p2=0", o_Game_Active, o_P2_Score);
    end
    tick(0, 0, 16, 10, 20);
    checks++;
    if (o_Game_Active !== 1'b0 || o_P2_Score !== 4'd1 || o_P1_Score !== 4'd0) begin
      errors++; $display("FAIL p1_miss: act=%b p1=%0d p2=%0d expected act=0 p1=0 p2=1",
                         o_Game_Active, o_P1_Score, o_P2_Score);
    end
  endtask

  task automatic test_point_hold();
    // Ball parked on the miss column while the point hold runs.
    for (int i = 0; i < HOLD - 1; i++) begin
      tick(0, 0, 16, 10, 20);
      checks++;
      if (o_Game_Active !== 1'b0 || o_P2_Score !== 4'd1) begin
        errors++; $display("FAIL point_hold[%0d]: act=%b p2=%0d expected act=0 p2=1",
                           i, o_Game_Active, o_P2_Score);
      end
    end
    tick(0, 20, 20, 10, 20);
    checks++;
    if (o_Game_Active !== 1'b1 || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL point_resume: got %h expected %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_game_over();
    for (int k = 0; k < LIMIT; k++) begin
      tick(0, W - 1, 0, 10, 20);
      for (int j = 0; j < HOLD && k < LIMIT - 1; j++) tick(0, 20, 20, 10, 20);
    end
    checks++;
    if (o_P1_Score !== 4'(LIMIT) || o_Game_Over !== 1'b1 || o_Winner !== 1'b0 || o_Game_Active !== 1'b0) begin
      errors++; $display("FAIL game_over: p1=%0d over=%b win=%b act=%b expected p1=%0d over=1 win=0 act=0",
                         o_P1_Score, o_Game_Over, o_Winner, o_Game_Active, LIMIT);
    end
    for (int j = 0; j < 3; j++) tick(0, W - 1, 0, 10, 20);
    checks++;
    if (o_P1_Score !== 4'(LIMIT) || o_P2_Score !== 4'd1 || o_Game_Over !== 1'b1) begin
      errors++; $display("FAIL game_over_hold: p1=%0d p2=%0d over=%b expected p1=%0d p2=1 over=1",
                         o_P1_Score, o_P2_Score, o_Game_Over, LIMIT);
    end
    tick(1, 20, 20, 10, 20);
    checks++;
    if (o_Game_Over !== 1'b0 || o_Game_Active !== 1'b0) begin
      errors++; $display("FAIL over_to_idle: over=%b act=%b expected over=0 act=0", o_Game_Over, o_Game_Active);
    end
    tick(0, 20, 20, 10, 20);
    tick(1, 20, 20, 10, 20);
    checks++;
    if (o_Game_Active !== 1'b1 || o_P1_Score !== 4'd0 || o_P2_Score !== 4'd0) begin
      errors++; $display("FAIL new_game: act=%b p1=%0d p2=%0d expected act=1 p1=0 p2=0",
                         o_Game_Active, o_P1_Score, o_P2_Score);
    end
    tick(0, 20, 20, 10, 20);
  endtask

  task automatic test_start_hold();
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1, 20, 20, 10, 10);
      if (o_Game_Active !== 1'b1 || dut_vec() !== model_vec()) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL start_held: %0d bad cycles, expected 0", bad);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(i[0], 20, 20, 10, 10);
      if (o_Game_Active !== 1'b1 || o_Game_Over !== 1'b0 || dut_vec() !== model_vec()) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL start_in_running: %0d bad cycles, expected 0", bad);
    end
  endtask

  task automatic test_random();
    int bx, r;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 9));
      bx = (r < 3) ? 0 : (r < 6) ? W - 1 : int'($urandom_range(1, W - 2));
      tick($urandom_range(0, 7) == 0, bx, int'($urandom_range(0, H - 1)),
           int'($urandom_range(0, H - PH)), int'($urandom_range(0, H - PH)));
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL random[%0d]: got %h expected %h", i, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(1, 20, 20, 10, 10);
    tick(0, 0, 0, 10, 10);   // P1 miss
    tick(0, 20, 20, 10, 10); // inside POINT
    checks++;
    if (o_Game_Active !== 1'b0 || o_P2_Score !== 4'd1) begin
      errors++; $display("FAIL pre_reset_point: act=%b p2=%0d expected act=0 p2=1", o_Game_Active, o_P2_Score);
    end
    #3;
    i_Rst = 1'b1;
    #1;
    checks++;
    if (dut_vec() !== 11'd0) begin
      errors++; $display("FAIL async_reset: got %h expected %h", dut_vec(), 11'd0);
    end
    #2;
    i_Rst = 1'b0;
    model_reset();
    tick(0, 20, 20, 10, 10);
    checks++;
    if (dut_vec() !== 11'd0) begin
      errors++; $display("FAIL post_reset_idle: got %h expected %h", dut_vec(), 11'd0);
    end
    tick(1, 20, 20, 10, 10);
    checks++;
    if (o_Game_Active !== 1'b1 || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL post_reset_serve: got %h expected %h", dut_vec(), model_vec());
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_hit_miss();
    test_point_hold();
    test_game_over();
    test_start_hold();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_game_fsm.md
Name:
pong_game_fsm

Overview:
- Top-level game sequencer for the Pong datapath.
- Owns the game-active enable that gates the ball controller: ball held at centre when inactive, moving when active.
- Watches ball position against both paddles, detects misses, keeps per-player scores and declares a winner.
- Inserts a hold period after each point so the ball recentres before play resumes.

Parameters:
- c_GAME_WIDTH, 40, board width in game units; P2 miss column is c_GAME_WIDTH-1.
- c_GAME_HEIGHT, 30, board height in game units; used only for range sanity in checks.
- c_PADDLE_HEIGHT, 6, paddle height in game units.
- c_SCORE_LIMIT, 9, score that ends the game; 1..15.
- c_POINT_HOLD, 25000000, clock cycles game stays inactive after a point (1 s at 25 MHz).

Ports:
- i_Clk  in  1  system clock
- i_Rst  in  1  reset, asynchronous, active-high
- i_Start  in  1  start/serve button, debounced level; only rising edge acts
- i_Ball_X  in  6  ball column from ball controller
- i_Ball_Y  in  6  ball row from ball controller
- i_Paddle_Y_P1  in  6  top row of P1 paddle (column 0)
- i_Paddle_Y_P2  in  6  top row of P2 paddle (column c_GAME_WIDTH-1)
- o_Game_Active  out  1  enable to ball controller; 1 only in RUNNING
- o_P1_Score  out  4  P1 points
- o_P2_Score  out  4  P2 points
- o_Game_Over  out  1  high in GAME_OVER
- o_Winner  out  1  0 = P1, 1 = P2; valid while o_Game_Over = 1

Behaviour:
Reset (i_Rst = 1, async):
- State IDLE; all outputs 0; hold counter 0; start-edge register 0.

Start edge:
- r_Start_Prev registered each cycle.
- Start pulse = i_Start & ~r_Start_Prev.
- Holding i_Start high gives exactly one pulse.

Paddle hit test:
- Combinational, 7-bit arithmetic, no wrap.
- Hit_Pn = (Ball_Y >= Paddle_Y_Pn) && (Ball_Y <= Paddle_Y_Pn + c_PADDLE_HEIGHT - 1).
- Miss_P1 = (Ball_X == 0) && !Hit_P1.
- Miss_P2 = (Ball_X == c_GAME_WIDTH-1) && !Hit_P2.

States:
- IDLE:
  - Outputs Active=0, Game_Over=0; scores hold.
  - Start pulse -> RUNNING; scores cleared to 0 on the same edge.
- RUNNING:
  - o_Game_Active = 1.
  - Miss_P1 -> o_P2_Score + 1.
  - Miss_P2 -> o_P1_Score + 1.
  - After the increment: new score == c_SCORE_LIMIT -> GAME_OVER, o_Winner set to the scorer. Otherwise -> POINT, hold counter cleared.
  - Only one miss per entry into RUNNING counts; the state exit prevents double counting while the ball lingers on the edge column.
  - Miss_P1 and Miss_P2 cannot coexist since c_GAME_WIDTH > 1; if both assert, Miss_P1 wins.
  - Start pulse ignored.
- POINT:
  - o_Game_Active = 0, so the ball recentres next cycle.
  - Counter increments each cycle; at c_POINT_HOLD-1 -> RUNNING.
  - Miss inputs ignored.
  - Start pulse ignored.
- GAME_OVER:
  - o_Game_Over = 1, Active = 0; scores and winner hold.
  - Start pulse -> IDLE; Game_Over clears.
  - A second start pulse then begins a new game.

Latency:
- Miss visible at inputs in cycle N: score and state update at edge N+1.
- o_Game_Active falls at edge N+1.
- All outputs are registered.

Reset mid-operation:
- Any state -> IDLE immediately.
- Scores and winner cleared; a partial hold count is discarded.

Test Plan:
- Reset then i_Start 0->1, Ball=(20,20) -> o_Game_Active=1 one cycle after the start edge; scores 0/0.
- RUNNING, P1 paddle Y=10, Ball=(0,12) -> P1 hit, no score change, stays RUNNING. Ball=(0,16) -> o_P2_Score=1 next cycle, Active=0.
- c_POINT_HOLD=4, after a point -> Active low exactly 4 cycles then high. Ball parked at (0,16) for 3 cycles during POINT -> score stays 1.
- c_SCORE_LIMIT=3, three P2 misses (Ball=(39,0), P2 paddle Y=20) -> o_P1_Score=3, o_Game_Over=1, o_Winner=0. Next start pulse -> IDLE. Following pulse -> RUNNING with scores 0/0.
- i_Start held high 100 cycles in IDLE -> single transition to RUNNING. Further pulses in RUNNING -> no effect.
- i_Rst asserted mid-POINT, asynchronously between clock edges -> outputs 0 before the next edge; state IDLE after release.
